// File: rtl/trng_pkg.sv
// Shared definitions for the entropy front end and the CRC sampler.
// Holds the conditioning FSM state encoding, a constant-evaluable clog2
// helper used to size counters, and the default health-test cutoffs that
// the sampling_unit_crc top level also refers to.
package trng_pkg;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_RUN     = 2'd1,
    ST_FAIL    = 2'd2
  } trng_state_t;

  localparam int TRNG_RCT_CUTOFF   = 32;
  localparam int TRNG_APT_WINDOW   = 512;
  localparam int TRNG_APT_CUTOFF   = 410;
  localparam int TRNG_STARTUP_BITS = 1024;

  // Ceiling log2; returns 0 for 1 so a "+1" width still yields one bit.
  function automatic int trng_clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/trng_health_tests.sv
// Repetition-count and adaptive-proportion health tests.
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   sample_en    one-cycle qualifier: 'sample' is a new health-tested sample
//   sample       the sample bit
//   restart      clears counters and sticky flags (takes priority over sample_en)
//   rct_fail     sticky repetition-count failure flag
//   apt_fail     sticky adaptive-proportion failure flag
//   rct_hit      combinational: this qualified sample trips the RCT cutoff
//   apt_hit      combinational: this qualified sample trips the APT cutoff
module trng_health_tests
  import trng_pkg::*;
#(
  parameter int RCT_CUTOFF = TRNG_RCT_CUTOFF,
  parameter int APT_WINDOW = TRNG_APT_WINDOW,
  parameter int APT_CUTOFF = TRNG_APT_CUTOFF
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic sample,
  input  logic restart,
  output logic rct_fail,
  output logic apt_fail,
  output logic rct_hit,
  output logic apt_hit
);

  localparam int RCT_W = trng_clog2(RCT_CUTOFF) + 1;
  localparam int APT_W = trng_clog2(APT_WINDOW) + 1;
  localparam logic [RCT_W-1:0] RCT_LIMIT = RCT_W'(RCT_CUTOFF);
  localparam logic [APT_W-1:0] APT_LIMIT = APT_W'(APT_CUTOFF);
  localparam logic [APT_W-1:0] WIN_LAST  = APT_W'(APT_WINDOW - 1);

  logic             have_prev;
  logic             prev_bit;
  logic [RCT_W-1:0] run_cnt;
  logic [RCT_W-1:0] run_next;
  logic             ref_bit;
  logic [APT_W-1:0] win_cnt;
  logic [APT_W-1:0] match_cnt;
  logic [APT_W-1:0] match_next;

  // Run length including the current sample; the first sample after reset
  // or restart always starts a fresh run of one. Saturates at the cutoff.
  always_comb begin
    run_next = RCT_W'(1);
    if (have_prev && (sample == prev_bit)) begin
      if (run_cnt == RCT_LIMIT) run_next = run_cnt;
      else                      run_next = run_cnt + 1'b1;
    end
  end

  // A window position of zero means this sample becomes the reference and
  // is itself the first match.
  always_comb begin
    match_next = APT_W'(1);
    if (win_cnt != '0) begin
      if ((sample == ref_bit) && (match_cnt != APT_LIMIT)) match_next = match_cnt + 1'b1;
      else                                                 match_next = match_cnt;
    end
  end

  assign rct_hit = sample_en && (run_next == RCT_LIMIT);
  assign apt_hit = sample_en && (match_next == APT_LIMIT);

  // Counter state and sticky flags; restart behaves like a local reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_prev <= 1'b0;
      prev_bit  <= 1'b0;
      run_cnt   <= '0;
      ref_bit   <= 1'b0;
      win_cnt   <= '0;
      match_cnt <= '0;
      rct_fail  <= 1'b0;
      apt_fail  <= 1'b0;
    end else if (restart) begin
      have_prev <= 1'b0;
      prev_bit  <= 1'b0;
      run_cnt   <= '0;
      ref_bit   <= 1'b0;
      win_cnt   <= '0;
      match_cnt <= '0;
      rct_fail  <= 1'b0;
      apt_fail  <= 1'b0;
    end else if (sample_en) begin
      have_prev <= 1'b1;
      prev_bit  <= sample;
      run_cnt   <= run_next;
      if (win_cnt == '0) ref_bit <= sample;
      match_cnt <= match_next;
      win_cnt   <= (win_cnt == WIN_LAST) ? '0 : win_cnt + 1'b1;
      if (rct_hit) rct_fail <= 1'b1;
      if (apt_hit) apt_fail <= 1'b1;
    end
  end

endmodule

// File: rtl/vn_debias_health.sv
// Entropy front end: synchronises and decimates the raw oscillator bit,
// health-tests the samples, applies von Neumann debiasing and gates the
// result with a STARTUP/RUN/FAIL state machine before sampling_unit_crc.
// Ports:
//   clk           system clock
//   rst           asynchronous, active-high reset
//   raw_bit       asynchronous raw entropy bit
//   clear_fail    one-cycle pulse; leaves FAIL and restarts STARTUP
//   debias_bit    debiased bit, qualified by debias_valid
//   debias_valid  one-cycle pulse
//   rct_fail      sticky repetition-count failure flag
//   apt_fail      sticky adaptive-proportion failure flag
//   src_ok        high only while in RUN
module vn_debias_health
  import trng_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int SAMPLE_DIV   = 4,
  parameter int RCT_CUTOFF   = TRNG_RCT_CUTOFF,
  parameter int APT_WINDOW   = TRNG_APT_WINDOW,
  parameter int APT_CUTOFF   = TRNG_APT_CUTOFF,
  parameter int STARTUP_BITS = TRNG_STARTUP_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_bit,
  input  logic clear_fail,
  output logic debias_bit,
  output logic debias_valid,
  output logic rct_fail,
  output logic apt_fail,
  output logic src_ok
);

  localparam int DIV_W = trng_clog2(SAMPLE_DIV) + 1;
  localparam int SU_W  = trng_clog2(STARTUP_BITS) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [SU_W-1:0]  SU_LIMIT = SU_W'(STARTUP_BITS);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_bit;
  logic [DIV_W-1:0]       div_cnt;
  logic                   tick;
  trng_state_t            state;
  trng_state_t            state_next;
  logic                   restart;
  logic                   sample_en;
  logic                   rct_hit;
  logic                   apt_hit;
  logic                   any_hit;
  logic [SU_W-1:0]        startup_cnt;
  logic [SU_W-1:0]        startup_inc;
  logic                   pair_full;
  logic                   pair_a;
  logic                   emit;

  // Plain shift-register synchroniser for the asynchronous oscillator bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw_bit};
  end

  assign s_bit = sync_q[SYNC_STAGES-1];

  // Free-running decimation counter; it is not affected by clear_fail so the
  // sample cadence stays fixed across restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_LAST);

  // Tests are frozen in FAIL so the sticky flags describe the failure that
  // caused the transition. A clear in FAIL restarts everything, and when it
  // lands on a tick that sample is simply dropped.
  assign restart   = clear_fail && (state == ST_FAIL);
  assign sample_en = tick && (state != ST_FAIL);
  assign any_hit   = rct_hit || apt_hit;

  trng_health_tests #(
    .RCT_CUTOFF (RCT_CUTOFF),
    .APT_WINDOW (APT_WINDOW),
    .APT_CUTOFF (APT_CUTOFF)
  ) u_health (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .sample    (s_bit),
    .restart   (restart),
    .rct_fail  (rct_fail),
    .apt_fail  (apt_fail),
    .rct_hit   (rct_hit),
    .apt_hit   (apt_hit)
  );

  // Startup sample count including the current tick, saturating at the target.
  always_comb begin
    if (startup_cnt == SU_LIMIT) startup_inc = startup_cnt;
    else                         startup_inc = startup_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                startup_cnt <= '0;
    else if (restart)                       startup_cnt <= '0;
    else if (tick && (state == ST_STARTUP)) startup_cnt <= startup_inc;
  end

  // A failure on the same tick that would finish startup still goes to FAIL.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_STARTUP: begin
        if (any_hit)                            state_next = ST_FAIL;
        else if (tick && (startup_inc == SU_LIMIT)) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (any_hit) state_next = ST_FAIL;
      end
      ST_FAIL: begin
        if (clear_fail) state_next = ST_STARTUP;
      end
      default: state_next = ST_STARTUP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_STARTUP;
    else     state <= state_next;
  end

  assign src_ok = (state == ST_RUN);

  // Pair phase advances on every tick in every state; only a restart or a
  // reset drops a half-collected pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_full <= 1'b0;
      pair_a    <= 1'b0;
    end else if (restart) begin
      pair_full <= 1'b0;
    end else if (tick) begin
      if (!pair_full) begin
        pair_a    <= s_bit;
        pair_full <= 1'b1;
      end else begin
        pair_full <= 1'b0;
      end
    end
  end

  // A differing pair yields its first bit, but only in RUN and only when the
  // completing tick does not also raise a health failure.
  assign emit = tick && pair_full && (pair_a != s_bit) && (state == ST_RUN) && !any_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      debias_valid <= 1'b0;
      debias_bit   <= 1'b0;
    end else begin
      debias_valid <= emit;
      if (emit) debias_bit <= pair_a;
    end
  end

endmodule

// File: tb/tb_vn_debias_health.sv
// Self-checking bench for vn_debias_health with small health parameters.
// Stimulus holds raw_bit for one full sample period per sample; a sample-level
// reference model predicts emitted bits and status, a monitor consumes them.
module tb_vn_debias_health;

  localparam int SYNC_STAGES  = 2;
  localparam int SAMPLE_DIV   = 4;
  localparam int RCT_CUTOFF   = 32;
  localparam int APT_WINDOW   = 64;
  localparam int APT_CUTOFF   = 50;
  localparam int STARTUP_BITS = 16;

  localparam int M_STARTUP = 0;
  localparam int M_RUN     = 1;
  localparam int M_FAIL    = 2;
  localparam int NO_CLEAR  = -1;

  logic clk = 1'b0;
  logic rst;
  logic raw_bit;
  logic clear_fail;
  logic debias_bit;
  logic debias_valid;
  logic rct_fail;
  logic apt_fail;
  logic src_ok;

  int checks = 0;
  int errors = 0;

  // Reference model state, expressed in terms of samples and windows.
  int         m_state;
  int         startup_ticks;
  int         run_len;
  bit         prev_valid;
  bit         prev_sample;
  bit         m_rct;
  bit         m_apt;
  bit         last_emit;
  bit         win_q[$];
  bit         pend_q[$];
  bit         exp_bit_q[$];
  logic [2:0] exp_status_q[$];
  logic [2:0] last_pushed;
  logic [2:0] last_seen;
  bit         monitor_on = 1'b0;

  vn_debias_health #(
    .SYNC_STAGES  (SYNC_STAGES),
    .SAMPLE_DIV   (SAMPLE_DIV),
    .RCT_CUTOFF   (RCT_CUTOFF),
    .APT_WINDOW   (APT_WINDOW),
    .APT_CUTOFF   (APT_CUTOFF),
    .STARTUP_BITS (STARTUP_BITS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .raw_bit      (raw_bit),
    .clear_fail   (clear_fail),
    .debias_bit   (debias_bit),
    .debias_valid (debias_valid),
    .rct_fail     (rct_fail),
    .apt_fail     (apt_fail),
    .src_ok       (src_ok)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [2:0] modelStatus();
    return {m_rct, m_apt, (m_state == M_RUN)};
  endfunction

  function automatic void pushStatus();
    logic [2:0] s;
    s = modelStatus();
    if (s != last_pushed) exp_status_q.push_back(s);
    last_pushed = s;
  endfunction

  function automatic int modelMatches();
    int m;
    m = 0;
    foreach (win_q[i]) if (win_q[i] == win_q[0]) m++;
    return m;
  endfunction

  function automatic void modelClearTests();
    m_state       = M_STARTUP;
    startup_ticks = 0;
    run_len       = 0;
    prev_valid    = 1'b0;
    prev_sample   = 1'b0;
    m_rct         = 1'b0;
    m_apt         = 1'b0;
    win_q.delete();
    pend_q.delete();
    pushStatus();
  endfunction

  // One sample tick of the reference model.
  function automatic void modelSample(input bit s);
    bit rct_hit;
    bit apt_hit;
    bit a;
    rct_hit   = 1'b0;
    apt_hit   = 1'b0;
    last_emit = 1'b0;
    if (m_state != M_FAIL) begin
      run_len     = (prev_valid && (s == prev_sample)) ? run_len + 1 : 1;
      prev_valid  = 1'b1;
      prev_sample = s;
      rct_hit     = (run_len >= RCT_CUTOFF);
      if (win_q.size() == APT_WINDOW) win_q.delete();
      win_q.push_back(s);
      apt_hit = (modelMatches() >= APT_CUTOFF);
      if (rct_hit) m_rct = 1'b1;
      if (apt_hit) m_apt = 1'b1;
    end
    if (pend_q.size() == 0) begin
      pend_q.push_back(s);
    end else begin
      a = pend_q.pop_front();
      if ((a != s) && (m_state == M_RUN) && !(rct_hit || apt_hit)) begin
        exp_bit_q.push_back(a);
        last_emit = 1'b1;
      end
    end
    if (m_state != M_FAIL) begin
      if (rct_hit || apt_hit) begin
        m_state = M_FAIL;
      end else if (m_state == M_STARTUP) begin
        startup_ticks++;
        if (startup_ticks == STARTUP_BITS) m_state = M_RUN;
      end
    end
    pushStatus();
  endfunction

  task automatic checkOutput();
    checkValue("status_after_tick", int'({rct_fail, apt_fail, src_ok}), int'(modelStatus()));
    checkValue("valid_timing", int'(debias_valid), int'(last_emit));
  endtask

  // Holds one sample for a full decimation period; clear_at selects the
  // cycle (0..SAMPLE_DIV-1) in which clear_fail is pulsed, or NO_CLEAR.
  task automatic applyStimulus(input bit b, input int clear_at);
    bit discard;
    discard = 1'b0;
    raw_bit = b;
    for (int i = 0; i < SAMPLE_DIV; i++) begin
      clear_fail = (i == clear_at);
      @(posedge clk);
      #1;
      if (i == clear_at) begin
        clear_fail = 1'b0;
        if (m_state == M_FAIL) begin
          modelClearTests();
          if (i == SAMPLE_DIV - 1) discard = 1'b1;
        end
      end
    end
    clear_fail = 1'b0;
    if (discard) last_emit = 1'b0;
    else         modelSample(b);
    @(negedge clk);
    checkOutput();
  endtask

  // Monitor: consumes expected debiased bits and status changes as the DUT shows them.
  initial begin : monitor
    logic [2:0] cur;
    logic [2:0] exp;
    bit         eb;
    forever begin
      @(negedge clk);
      if (monitor_on) begin
        cur = {rct_fail, apt_fail, src_ok};
        if (cur != last_seen) begin
          if (exp_status_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL status_unexpected: got %b expected %b at %0t", cur, last_seen, $time);
          end else begin
            exp = exp_status_q.pop_front();
            checkValue("status_change", int'(cur), int'(exp));
          end
          last_seen = cur;
        end
        if (debias_valid) begin
          if (exp_bit_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL debias_unexpected: got valid bit %0d expected no output at %0t", debias_bit, $time);
          end else begin
            eb = exp_bit_q.pop_front();
            checkValue("debias_bit", int'(debias_bit), int'(eb));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int m;
    bit ref_one;
    rst        = 1'b0;
    raw_bit    = 1'b0;
    clear_fail = 1'b0;
    last_pushed = 3'b000;
    last_seen   = 3'b000;
    modelClearTests();
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkValue("reset_debias_bit",   int'(debias_bit),   0);
    checkValue("reset_debias_valid", int'(debias_valid), 0);
    checkValue("reset_rct_fail",     int'(rct_fail),     0);
    checkValue("reset_apt_fail",     int'(apt_fail),     0);
    checkValue("reset_src_ok",       int'(src_ok),       0);
    rst = 1'b0;
    monitor_on = 1'b1;

    $display("[TB] alternating stream through startup");
    for (int i = 0; i < 36; i++) applyStimulus(bit'(i % 2), NO_CLEAR);
    checkValue("alt_src_ok", int'(src_ok), 1);

    $display("[TB] random unbiased stream");
    for (int i = 0; i < 80; i++) applyStimulus(bit'($urandom_range(1, 0)), NO_CLEAR);

    $display("[TB] APT cutoff on a differing pair");
    for (int n = 0; n < 300 && m_state == M_RUN; n++) begin
      m = modelMatches();
      ref_one = (win_q.size() > 0) && (win_q[0] == 1'b1) && (win_q.size() <= APT_WINDOW - 2);
      if (ref_one && m == APT_CUTOFF - 1 && pend_q.size() == 0) begin
        applyStimulus(1'b0, NO_CLEAR);
        applyStimulus(1'b1, NO_CLEAR);
      end else if (ref_one && m == APT_CUTOFF - 1) begin
        applyStimulus(1'b0, NO_CLEAR);
      end else if (ref_one && m == APT_CUTOFF - 2) begin
        applyStimulus(pend_q.size() == 0 ? 1'b0 : 1'b1, NO_CLEAR);
      end else if (prev_valid && prev_sample && run_len >= 25) begin
        applyStimulus(1'b0, NO_CLEAR);
      end else begin
        applyStimulus(1'b1, NO_CLEAR);
      end
    end
    checkValue("apt_fail_raised", int'(apt_fail), 1);
    checkValue("apt_src_ok_low",  int'(src_ok),   0);

    $display("[TB] clear before tick, restart and constant ones");
    applyStimulus(1'b1, 0);
    for (int i = 0; i < 20; i++) applyStimulus(bit'(i % 2), NO_CLEAR);
    checkValue("restart_src_ok", int'(src_ok), 1);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, NO_CLEAR);
    checkValue("rct_fail_raised", int'(rct_fail), 1);
    checkValue("rct_src_ok_low",  int'(src_ok),   0);

    $display("[TB] clear on tick, then biased stream");
    applyStimulus(1'b0, SAMPLE_DIV - 1);
    checkValue("clear_flags_rct", int'(rct_fail), 0);
    for (int i = 0; i < 150 && m_state != M_FAIL; i++)
      applyStimulus(bit'($urandom_range(7, 0) != 0), NO_CLEAR);
    checkValue("biased_fail_state", int'(src_ok), 0);

    $display("[TB] reset in the middle of a pair");
    applyStimulus(1'b0, 1);
    for (int i = 0; i < 20; i++) applyStimulus(bit'(i % 2), NO_CLEAR);
    #2 rst = 1'b1;
    modelClearTests();
    #1;
    checkValue("midreset_debias_valid", int'(debias_valid), 0);
    checkValue("midreset_debias_bit",   int'(debias_bit),   0);
    checkValue("midreset_src_ok",       int'(src_ok),       0);
    checkValue("midreset_rct_fail",     int'(rct_fail),     0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 24; i++) applyStimulus(bit'((i + 1) % 2), NO_CLEAR);

    repeat (8) @(negedge clk);
    checkValue("unconsumed_bits",   exp_bit_q.size(),    0);
    checkValue("unconsumed_status", exp_status_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
